// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: majority-voted sampling, false-start rejection,
// ready/ack handshake with overrun; break detection when UART_RX_BREAK_EN is defined.
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 uart_clk,
    input  logic                 rxd,
    input  logic                 ack,
    output logic                 ready,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [CW-1:0] C_S0   = CW'(M - 1);
    localparam logic [CW-1:0] C_S1   = CW'(M);
    localparam logic [CW-1:0] C_DEC  = CW'(M + 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_RX_BREAK_EN
        , S_BREAK
`endif
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rxs;
    logic [CW-1:0]          cnt;
    logic [3:0]             bit_cnt;
    logic                   samp0;
    logic                   samp1;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_acc;
    logic                   par_bad;
    logic                   stop_err;
    logic                   maj;
    logic                   at_dec;
    logic                   at_wrap;
`ifdef UART_RX_BREAK_EN
    logic                   all_zero;
`endif

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    // The third sample is the live rxs at the decision tick itself
    assign maj     = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
    assign at_dec  = uart_clk && (cnt == C_DEC);
    assign at_wrap = uart_clk && (cnt == C_LAST);

`ifndef UART_RX_BREAK_EN
    assign break_det = 1'b0;
`endif

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            samp0      <= 1'b1;
            samp1      <= 1'b1;
            shreg      <= '0;
            par_acc    <= 1'b0;
            par_bad    <= 1'b0;
            stop_err   <= 1'b0;
            ready      <= 1'b0;
            data       <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_BREAK_EN
            all_zero   <= 1'b0;
            break_det  <= 1'b0;
`endif
        end else begin
            // Completion assignments below come later and therefore win over ack
            if (ack) begin
                ready   <= 1'b0;
                overrun <= 1'b0;
`ifdef UART_RX_BREAK_EN
                break_det <= 1'b0;
`endif
            end

            if (uart_clk) begin
                if (state != S_IDLE) begin
                    cnt <= (cnt == C_LAST) ? '0 : cnt + CW'(1);
                    if (cnt == C_S0) samp0 <= rxs;
                    if (cnt == C_S1) samp1 <= rxs;
                end

                unique case (state)
                    S_IDLE: begin
                        if (!rxs) begin
                            state    <= S_START;
                            cnt      <= CW'(1);
                            bit_cnt  <= '0;
                            par_acc  <= 1'b0;
                            par_bad  <= 1'b0;
                            stop_err <= 1'b0;
`ifdef UART_RX_BREAK_EN
                            all_zero <= 1'b1;
`endif
                        end
                    end
                    S_START: begin
                        if (at_dec && maj)
                            state <= S_IDLE;
                        else if (at_wrap)
                            state <= S_DATA;
                    end
                    S_DATA: begin
                        if (at_dec) begin
                            shreg   <= {maj, shreg[DATA_BITS-1:1]};
                            par_acc <= par_acc ^ maj;
`ifdef UART_RX_BREAK_EN
                            all_zero <= all_zero & ~maj;
`endif
                        end else if (at_wrap) begin
                            if (bit_cnt == LAST_DATA) begin
                                bit_cnt <= '0;
                                state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (at_dec) begin
                            par_bad <= par_acc ^ maj ^ (PARITY == 2);
`ifdef UART_RX_BREAK_EN
                            all_zero <= all_zero & ~maj;
`endif
                        end else if (at_wrap) begin
                            state <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (at_dec) begin
`ifdef UART_RX_BREAK_EN
                            if (bit_cnt == 4'd0 && all_zero && !maj) begin
                                data       <= '0;
                                parity_err <= 1'b0;
                                frame_err  <= 1'b1;
                                break_det  <= 1'b1;
                                ready      <= 1'b1;
                                overrun    <= ready & ~ack;
                                state      <= S_BREAK;
                            end else
`endif
                            if (bit_cnt == LAST_STOP) begin
                                data       <= shreg;
                                parity_err <= (PARITY != 0) ? par_bad : 1'b0;
                                frame_err  <= stop_err | ~maj;
                                ready      <= 1'b1;
                                overrun    <= ready & ~ack;
                                state      <= S_IDLE;
                            end else begin
                                stop_err <= stop_err | ~maj;
                            end
                        end else if (at_wrap) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
`ifdef UART_RX_BREAK_EN
                    S_BREAK: begin
                        if (rxs) state <= S_IDLE;
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three parameterisations driven from one initial block.
module tb_uart_rx_cfg;

    localparam int DIV     = 2;
    localparam int OS      = 16;
    localparam int BIT_CLK = OS * DIV;

    typedef struct packed {
        logic       rdy;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
        logic       brk;
    } rep_t;

    logic       clk;
    logic       nRST;
    logic       uart_clk;
    logic       rxd_v [3];
    logic       ack_v [3];
    logic       ready_v [3];
    logic       perr_v [3];
    logic       ferr_v [3];
    logic       ovr_v [3];
    logic       brk_v [3];
    logic [7:0] data0;
    logic [7:0] data1;
    logic [6:0] data2;

    rep_t sb[$];
    rep_t e;
    int   total;
    int   bad;
    int   lat;

    uart_rx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(OS)) dut_even (
        .clk(clk), .nRST(nRST), .uart_clk(uart_clk), .rxd(rxd_v[0]), .ack(ack_v[0]),
        .ready(ready_v[0]), .data(data0), .parity_err(perr_v[0]), .frame_err(ferr_v[0]),
        .overrun(ovr_v[0]), .break_det(brk_v[0]));

    uart_rx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(OS)) dut_odd (
        .clk(clk), .nRST(nRST), .uart_clk(uart_clk), .rxd(rxd_v[1]), .ack(ack_v[1]),
        .ready(ready_v[1]), .data(data1), .parity_err(perr_v[1]), .frame_err(ferr_v[1]),
        .overrun(ovr_v[1]), .break_det(brk_v[1]));

    uart_rx_cfg #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(OS)) dut_7n2 (
        .clk(clk), .nRST(nRST), .uart_clk(uart_clk), .rxd(rxd_v[2]), .ack(ack_v[2]),
        .ready(ready_v[2]), .data(data2), .parity_err(perr_v[2]), .frame_err(ferr_v[2]),
        .overrun(ovr_v[2]), .break_det(brk_v[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int div;
        div = 0;
        uart_clk = 1'b0;
        forever begin
            @(negedge clk);
            div = (div + 1) % DIV;
            uart_clk = (div == 0);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    function automatic rep_t snap(input int i);
        rep_t r;
        r.rdy  = ready_v[i];
        r.data = (i == 0) ? {1'b0, data0} : (i == 1) ? {1'b0, data1} : {2'b00, data2};
        r.perr = perr_v[i];
        r.ferr = ferr_v[i];
        r.ovr  = ovr_v[i];
        r.brk  = brk_v[i];
        return r;
    endfunction

    function automatic rep_t mk(input logic rdy, input logic [8:0] d, input logic perr,
                                input logic ferr, input logic ovr, input logic brk);
        rep_t r;
        r.rdy = rdy; r.data = d; r.perr = perr; r.ferr = ferr; r.ovr = ovr; r.brk = brk;
        return r;
    endfunction

    task automatic align_tick();
        do @(posedge clk); while (uart_clk !== 1'b1);
        @(negedge clk);
    endtask

    task automatic drive_bit(input int idx, input logic b);
        rxd_v[idx] = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic idle_bits(input int idx, input int n);
        rxd_v[idx] = 1'b1;
        repeat (n * BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame_raw(input int idx, input int nbits, input logic [8:0] d,
                                  input bit has_par, input logic pbit,
                                  input int nstop, input logic [1:0] stops);
        drive_bit(idx, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(idx, d[i]);
        if (has_par) drive_bit(idx, pbit);
        for (int i = 0; i < nstop; i++) drive_bit(idx, stops[i]);
        rxd_v[idx] = 1'b1;
    endtask

    task automatic send_frame(input int idx, input int nbits, input logic [8:0] d,
                              input bit has_par, input logic pbit,
                              input int nstop, input logic [1:0] stops);
        align_tick();
        send_frame_raw(idx, nbits, d, has_par, pbit, nstop, stops);
    endtask

    task automatic wait_ready(input int idx);
        for (int i = 0; i < BIT_CLK; i++) begin
            if (ready_v[idx] === 1'b1) break;
            @(negedge clk);
        end
    endtask

    task automatic pulse_ack(input int idx);
        @(negedge clk);
        ack_v[idx] = 1'b1;
        @(negedge clk);
        ack_v[idx] = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rxd_v[i] = 1'b1;
            ack_v[i] = 1'b0;
        end
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (snap(i) !== mk(0, 9'h000, 0, 0, 0, 0)) begin
                bad++;
                $display("[TB] FAIL reset_state inst=%0d got=%h want=%h", i, snap(i), mk(0, 9'h000, 0, 0, 0, 0));
            end
        end
        nRST = 1'b1;
        idle_bits(0, 2);
    endtask

    task automatic test_basic_frame();
        sb.push_back(mk(1, 9'h0A5, 0, 0, 0, 0));
        send_frame(0, 8, 9'h0A5, 1, 1'b0, 1, 2'b11);
        wait_ready(0);
        e = sb.pop_front();
        total++;
        if (snap(0) !== e) begin
            bad++;
            $display("[TB] FAIL basic_a5 got=%h want=%h", snap(0), e);
        end
        idle_bits(0, 2);
    endtask

    task automatic test_parity();
        pulse_ack(0);
        sb.push_back(mk(1, 9'h0A5, 1, 0, 0, 0));
        send_frame(0, 8, 9'h0A5, 1, 1'b1, 1, 2'b11);
        wait_ready(0);
        e = sb.pop_front();
        total++;
        if (snap(0) !== e) begin
            bad++;
            $display("[TB] FAIL even_parity_err got=%h want=%h", snap(0), e);
        end
        idle_bits(0, 2);
        sb.push_back(mk(1, 9'h0A5, 0, 0, 0, 0));
        send_frame(1, 8, 9'h0A5, 1, 1'b1, 1, 2'b11);
        wait_ready(1);
        e = sb.pop_front();
        total++;
        if (snap(1) !== e) begin
            bad++;
            $display("[TB] FAIL odd_parity_ok got=%h want=%h", snap(1), e);
        end
        idle_bits(1, 2);
    endtask

    task automatic test_stop_bits();
        sb.push_back(mk(1, 9'h05A, 0, 1, 0, 0));
        send_frame(2, 7, 9'h05A, 0, 1'b0, 2, 2'b01);
        wait_ready(2);
        e = sb.pop_front();
        total++;
        if (snap(2) !== e) begin
            bad++;
            $display("[TB] FAIL stop2_low got=%h want=%h", snap(2), e);
        end
        idle_bits(2, 2);
        pulse_ack(2);
        sb.push_back(mk(1, 9'h05A, 0, 0, 0, 0));
        send_frame(2, 7, 9'h05A, 0, 1'b0, 2, 2'b11);
        wait_ready(2);
        e = sb.pop_front();
        total++;
        if (snap(2) !== e) begin
            bad++;
            $display("[TB] FAIL stop2_high got=%h want=%h", snap(2), e);
        end
        idle_bits(2, 2);
    endtask

    task automatic test_false_start();
        pulse_ack(0);
        align_tick();
        rxd_v[0] = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        idle_bits(0, 2);
        total++;
        if (ready_v[0] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL glitch_ready got=%b want=0", ready_v[0]);
        end
        sb.push_back(mk(1, 9'h03C, 0, 0, 0, 0));
        send_frame(0, 8, 9'h03C, 1, 1'b0, 1, 2'b11);
        wait_ready(0);
        e = sb.pop_front();
        total++;
        if (snap(0) !== e) begin
            bad++;
            $display("[TB] FAIL after_glitch got=%h want=%h", snap(0), e);
        end
        idle_bits(0, 2);
    endtask

    task automatic test_back_to_back();
        pulse_ack(0);
        sb.push_back(mk(1, 9'h011, 0, 0, 0, 0));
        sb.push_back(mk(1, 9'h022, 0, 0, 1, 0));
        send_frame(0, 8, 9'h011, 1, 1'b0, 1, 2'b11);
        wait_ready(0);
        e = sb.pop_front();
        total++;
        if (snap(0) !== e) begin
            bad++;
            $display("[TB] FAIL b2b_first got=%h want=%h", snap(0), e);
        end
        send_frame_raw(0, 8, 9'h022, 1, 1'b0, 1, 2'b11);
        e = sb.pop_front();
        total++;
        if (snap(0) !== e) begin
            bad++;
            $display("[TB] FAIL b2b_overrun got=%h want=%h", snap(0), e);
        end
        idle_bits(0, 2);
        pulse_ack(0);
        total++;
        if (snap(0) !== mk(0, 9'h022, 0, 0, 0, 0)) begin
            bad++;
            $display("[TB] FAIL ack_clears got=%h want=%h", snap(0), mk(0, 9'h022, 0, 0, 0, 0));
        end

        // Measure tick-aligned start-to-completion latency, then land ack on that clk
        sb.push_back(mk(1, 9'h033, 0, 0, 0, 0));
        align_tick();
        lat = 0;
        fork
            send_frame_raw(0, 8, 9'h033, 1, 1'b0, 1, 2'b11);
            begin
                do begin
                    @(posedge clk);
                    lat++;
                    #1;
                end while (ready_v[0] !== 1'b1 && lat < 20 * BIT_CLK);
            end
        join
        total++;
        if (ready_v[0] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL latency_timeout got_ready=%b want=1", ready_v[0]);
        end
        e = sb.pop_front();
        total++;
        if (snap(0) !== e) begin
            bad++;
            $display("[TB] FAIL frame_33 got=%h want=%h", snap(0), e);
        end
        idle_bits(0, 2);

        sb.push_back(mk(1, 9'h044, 0, 0, 0, 0));
        align_tick();
        fork
            send_frame_raw(0, 8, 9'h044, 1, 1'b0, 1, 2'b11);
            begin
                repeat (lat - 1) @(posedge clk);
                @(negedge clk);
                ack_v[0] = 1'b1;
                @(negedge clk);
                ack_v[0] = 1'b0;
            end
        join
        e = sb.pop_front();
        total++;
        if (snap(0) !== e) begin
            bad++;
            $display("[TB] FAIL ack_at_completion got=%h want=%h", snap(0), e);
        end
        idle_bits(0, 2);
        pulse_ack(0);
    endtask

    task automatic test_break();
        align_tick();
`ifdef UART_RX_BREAK_EN
        sb.push_back(mk(1, 9'h000, 0, 1, 0, 1));
`else
        sb.push_back(mk(1, 9'h000, 0, 1, 0, 0));
`endif
        rxd_v[0] = 1'b0;
        repeat (12 * BIT_CLK) @(negedge clk);
        e = sb.pop_front();
        total++;
        if (snap(0) !== e) begin
            bad++;
            $display("[TB] FAIL break_report got=%h want=%h", snap(0), e);
        end
        idle_bits(0, 14);
`ifdef UART_RX_BREAK_EN
        total++;
        if (snap(0) !== mk(1, 9'h000, 0, 1, 0, 1)) begin
            bad++;
            $display("[TB] FAIL break_single got=%h want=%h", snap(0), mk(1, 9'h000, 0, 1, 0, 1));
        end
        pulse_ack(0);
        total++;
        if (snap(0) !== mk(0, 9'h000, 0, 1, 0, 0)) begin
            bad++;
            $display("[TB] FAIL break_ack got=%h want=%h", snap(0), mk(0, 9'h000, 0, 1, 0, 0));
        end
`else
        total++;
        if (brk_v[0] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL break_const got=%b want=0", brk_v[0]);
        end
        pulse_ack(0);
`endif
        sb.push_back(mk(1, 9'h07E, 0, 0, 0, 0));
        send_frame(0, 8, 9'h07E, 1, 1'b0, 1, 2'b11);
        wait_ready(0);
        e = sb.pop_front();
        total++;
        if (snap(0) !== e) begin
            bad++;
            $display("[TB] FAIL after_break got=%h want=%h", snap(0), e);
        end
        idle_bits(0, 2);
    endtask

    task automatic test_reset_mid_frame();
        align_tick();
        rxd_v[0] = 1'b0;
        repeat (4 * BIT_CLK) @(negedge clk);
        nRST = 1'b0;
        rxd_v[0] = 1'b1;
        #1;
        total++;
        if (snap(0) !== mk(0, 9'h000, 0, 0, 0, 0)) begin
            bad++;
            $display("[TB] FAIL mid_reset got=%h want=%h", snap(0), mk(0, 9'h000, 0, 0, 0, 0));
        end
        repeat (5) @(negedge clk);
        nRST = 1'b1;
        idle_bits(0, 15);
        total++;
        if (snap(0) !== mk(0, 9'h000, 0, 0, 0, 0)) begin
            bad++;
            $display("[TB] FAIL no_report_after_reset got=%h want=%h", snap(0), mk(0, 9'h000, 0, 0, 0, 0));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic_frame();
        test_parity();
        test_stop_bits();
        test_false_start();
        test_back_to_back();
        test_break();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
